tmds_word_aligner: RTL and testbench



---
 rtl/tmds_pkg.sv | 43 ++++
 rtl/tmds_word_aligner_if.sv | 23 ++
 rtl/token_detector.sv | 23 ++
 rtl/tmds_word_aligner.sv | 153 +++++++++++++++
 tb/tb_tmds_word_aligner.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS constants, lock FSM state encoding and control-token decode.
package tmds_pkg;

    localparam int unsigned SYM_W = 10;
    localparam int unsigned BUF_W = 2 * SYM_W;
    localparam int unsigned LOC_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned N_OFF = SYM_W;

    localparam logic [SYM_W-1:0] CT0 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CT1 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CT2 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CT3 = 10'b1010101011;

    localparam logic [LOC_W-1:0] LOC_NONE = 4'd15;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] c;
    } ctrl_dec_t;

    // Map a symbol to {is_ctrl, C1C0}; non-tokens report is_ctrl = 0.
    function automatic ctrl_dec_t ctrl_decode(input logic [SYM_W-1:0] sym);
        ctrl_dec_t d;
        d.is_ctrl = 1'b1;
        d.c       = 2'b00;
        case (sym)
            CT0:     d.c = 2'b00;
            CT1:     d.c = 2'b01;
            CT2:     d.c = 2'b10;
            CT3:     d.c = 2'b11;
            default: d.is_ctrl = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tmds_word_aligner_if.sv
// Raw-word input and aligned-symbol output bundle of one TMDS channel aligner.
interface tmds_word_aligner_if;

    logic                                  in_valid;
    logic [tmds_pkg::SYM_W-1:0]            in_word;
    logic                                  out_valid;
    logic [tmds_pkg::SYM_W-1:0]            out_word;
    logic                                  out_ctrl;
    logic [1:0]                            out_c;
    logic                                  locked;
    logic [tmds_pkg::LOC_W-1:0]            lock_off;

    modport master (
        output in_valid, in_word,
        input  out_valid, out_word, out_ctrl, out_c, locked, lock_off
    );

    modport slave (
        input  in_valid, in_word,
        output out_valid, out_word, out_ctrl, out_c, locked, lock_off
    );

endinterface

// File: rtl/token_detector.sv
// Finds the lowest bit offset in the 20-bit search buffer holding a control token.
module token_detector
    import tmds_pkg::*;
(
    input  logic [BUF_W-1:0] search,
    output logic [LOC_W-1:0] loc
);

    ctrl_dec_t dec;

    // Scan high to low so the lowest matching offset is the one left standing.
    always_comb begin
        loc = LOC_NONE;
        dec = '0;
        for (int i = int'(N_OFF) - 1; i >= 0; i--) begin
            dec = ctrl_decode(search[i +: SYM_W]);
            if (dec.is_ctrl) begin
                loc = LOC_W'(i);
            end
        end
    end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: search buffer, token-driven lock FSM, aligned symbol
// output and control-period C1/C0 decode.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 8,
    parameter int unsigned UNLOCK_COUNT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    tmds_word_aligner_if.slave  bus
);

    localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_COUNT);

    logic [BUF_W-1:0] sbuf, sbuf_d;
    logic             s1_v;
    lock_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [LOC_W-1:0] cand, cand_d, off, off_d, loc;
    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_word_q, out_word_d, aligned;
    logic             out_ctrl_q, out_ctrl_d;
    logic [1:0]       out_c_q, out_c_d;
    logic             locked_q, locked_d;
    ctrl_dec_t        dec;

    token_detector u_det (
        .search (sbuf),
        .loc    (loc)
    );

    // Next-state logic for stage 1, the lock FSM and the output stage.
    always_comb begin
        sbuf_d      = sbuf;
        state_d     = state;
        cnt_d       = cnt;
        cand_d      = cand;
        off_d       = off;
        out_valid_d = 1'b0;
        out_word_d  = out_word_q;
        out_ctrl_d  = out_ctrl_q;
        out_c_d     = out_c_q;
        cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        aligned     = SYM_W'(sbuf >> off);
        dec         = ctrl_decode(aligned);

        if (bus.in_valid) begin
            sbuf_d = {bus.in_word, sbuf[BUF_W-1:SYM_W]};
        end

        if (s1_v) begin
            // Emission uses the pre-update state and offset.
            if (state == LOCKED) begin
                out_valid_d = 1'b1;
                out_word_d  = aligned;
                out_ctrl_d  = dec.is_ctrl;
                if (dec.is_ctrl) begin
                    out_c_d = dec.c;
                end
            end

            case (state)
                SEARCH: begin
                    if (loc != LOC_NONE) begin
                        if (LOCK_TGT == CNT_W'(1)) begin
                            state_d = LOCKED;
                            off_d   = loc;
                            cnt_d   = '0;
                        end else begin
                            state_d = VERIFY;
                            cand_d  = loc;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                VERIFY: begin
                    if (loc == cand) begin
                        if (cnt_inc == LOCK_TGT) begin
                            state_d = LOCKED;
                            off_d   = cand;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (loc == LOC_NONE) begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cand_d = loc;
                        cnt_d  = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    // Misses are ignored: data periods carry no tokens.
                    if (loc == off) begin
                        cnt_d = '0;
                    end else if (loc != LOC_NONE) begin
                        if (cnt_inc == UNLOCK_TGT) begin
                            state_d = SEARCH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf        <= '0;
            s1_v        <= 1'b0;
            state       <= SEARCH;
            cnt         <= '0;
            cand        <= '0;
            off         <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_ctrl_q  <= 1'b0;
            out_c_q     <= 2'b00;
            locked_q    <= 1'b0;
        end else begin
            sbuf        <= sbuf_d;
            s1_v        <= bus.in_valid;
            state       <= state_d;
            cnt         <= cnt_d;
            cand        <= cand_d;
            off         <= off_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_ctrl_q  <= out_ctrl_d;
            out_c_q     <= out_c_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign bus.out_c     = out_c_q;
    assign bus.locked    = locked_q;
    assign bus.lock_off  = off;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: symbols are serialised into a bit
// stream with a chosen bit offset and re-cut into raw 10-bit words.
module tb_tmds_word_aligner;

    localparam logic [9:0] K_CT0 = 10'b1101010100;
    localparam logic [9:0] K_CT1 = 10'b0010101011;
    localparam logic [9:0] K_CT2 = 10'b0101010100;
    localparam logic [9:0] K_CT3 = 10'b1010101011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tmds_word_aligner_if bus ();

    tmds_word_aligner #(
        .LOCK_COUNT   (8),
        .UNLOCK_COUNT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         bitq[$];
    logic [9:0] prev_sym;

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bitq.delete();
    endtask

    task automatic add_gap_bits(input int n);
        for (int i = 0; i < n; i++) bitq.push_back(1'b0);
    endtask

    // One raw word, then an idle cycle so stage 2 has consumed it on return.
    task automatic send_word(input logic [9:0] w);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_sym(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
        if (bitq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
            send_word(w);
        end
        prev_sym = s;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({bus.out_valid, bus.out_word, bus.out_ctrl, bus.out_c, bus.locked, bus.lock_off} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset.outputs: got %h required 0", {bus.out_valid, bus.out_word, bus.out_ctrl, bus.out_c, bus.locked, bus.lock_off});
        end
    endtask

    task automatic test_clean_lock();
        do_reset();
        add_gap_bits(3);
        for (int k = 0; k < 9; k++) begin
            push_sym(K_CT2);
            n_tests++;
            if (bus.locked !== (k == 8) || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_lock.word%0d: locked=%b out_valid=%b required locked=%b out_valid=0", k, bus.locked, bus.out_valid, (k == 8));
            end
        end
        n_tests++;
        if (bus.lock_off !== 4'd3) begin
            n_fail++;
            $display("FAIL clean_lock.lock_off: got %0d required 3", bus.lock_off);
        end
        push_sym(K_CT2);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== K_CT2 || bus.out_ctrl !== 1'b1 || bus.out_c !== 2'b10) begin
            n_fail++;
            $display("FAIL clean_lock.first_word: v=%b w=%b ctrl=%b c=%b required v=1 w=%b ctrl=1 c=10", bus.out_valid, bus.out_word, bus.out_ctrl, bus.out_c, K_CT2);
        end
    endtask

    task automatic test_blanking();
        logic [9:0] data[4] = '{10'b0111001100, 10'b1001110001, 10'b1100011110, 10'b0011100011};
        logic [9:0] exp_w;
        logic [1:0] exp_c;
        for (int i = 0; i < 20; i++) begin
            exp_w = (i == 0) ? K_CT2 : K_CT0;
            exp_c = (i == 0) ? 2'b10 : 2'b00;
            push_sym(K_CT0);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_word !== exp_w || bus.out_ctrl !== 1'b1 || bus.out_c !== exp_c || bus.locked !== 1'b1) begin
                n_fail++;
                $display("FAIL blanking.ct0_%0d: v=%b w=%b ctrl=%b c=%b locked=%b required v=1 w=%b ctrl=1 c=%b locked=1", i, bus.out_valid, bus.out_word, bus.out_ctrl, bus.out_c, bus.locked, exp_w, exp_c);
            end
        end
        push_sym(data[0]);
        for (int i = 1; i < 4; i++) begin
            push_sym(data[i]);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_word !== data[i-1] || bus.out_ctrl !== 1'b0 || bus.out_c !== 2'b00 || bus.locked !== 1'b1) begin
                n_fail++;
                $display("FAIL blanking.data_%0d: v=%b w=%b ctrl=%b c=%b locked=%b required v=1 w=%b ctrl=0 c=00 locked=1", i, bus.out_valid, bus.out_word, bus.out_ctrl, bus.out_c, bus.locked, data[i-1]);
            end
        end
    endtask

    task automatic test_stall();
        logic [9:0] syms[24] = '{K_CT3, 10'h2F0, 10'h10F, K_CT0, 10'h1E3, 10'h31C,
                                 K_CT1, 10'h0F8, 10'h307, K_CT3, 10'h2C6, 10'h139,
                                 K_CT2, 10'h3E0, 10'h01F, K_CT0, 10'h266, 10'h199,
                                 K_CT3, 10'h2D2, 10'h12D, K_CT1, 10'h3C3, 10'h03C};
        logic [9:0] words[$];
        logic [9:0] exp_q[$];
        logic [9:0] got[$];
        logic [9:0] w;
        int         idx = 0;
        int         cyc = 0;
        exp_q.push_back(prev_sym);
        for (int s = 0; s < 24; s++) begin
            for (int i = 0; i < 10; i++) bitq.push_back(syms[s][i]);
            for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
            words.push_back(w);
            if (s < 23) exp_q.push_back(syms[s]);
        end
        while (idx < words.size() && cyc < 2000) begin
            if ($urandom_range(1, 0) == 1) begin
                bus.in_valid = 1'b1;
                bus.in_word  = words[idx];
                idx++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid === 1'b1) got.push_back(bus.out_word);
        end
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) got.push_back(bus.out_word);
        end
        prev_sym = syms[23];
        n_tests++;
        if (got.size() != exp_q.size() || idx != words.size()) begin
            n_fail++;
            $display("FAIL stall.count: got %0d words (%0d sent) required %0d", got.size(), idx, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall.word%0d: got %b required %b", i, got[i], exp_q[i]);
            end
        end
        n_tests++;
        if (bus.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL stall.locked: got %b required 1", bus.locked);
        end
    endtask

    task automatic test_slip();
        push_sym(K_CT2);
        push_sym(K_CT2);
        add_gap_bits(3);
        push_sym(K_CT2);
        n_tests++;
        if (bus.locked !== 1'b1 || bus.out_word !== K_CT2) begin
            n_fail++;
            $display("FAIL slip.first: locked=%b w=%b required locked=1 w=%b", bus.locked, bus.out_word, K_CT2);
        end
        for (int i = 1; i <= 16; i++) begin
            push_sym(K_CT2);
            n_tests++;
            if (bus.locked !== (i < 16) || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL slip.drift%0d: locked=%b v=%b required locked=%b v=1", i, bus.locked, bus.out_valid, (i < 16));
            end
        end
        for (int j = 1; j <= 8; j++) begin
            push_sym(K_CT2);
            n_tests++;
            if (bus.locked !== (j == 8) || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL slip.relock%0d: locked=%b v=%b required locked=%b v=0", j, bus.locked, bus.out_valid, (j == 8));
            end
        end
        push_sym(K_CT2);
        n_tests++;
        if (bus.lock_off !== 4'd6 || bus.out_valid !== 1'b1 || bus.out_word !== K_CT2) begin
            n_fail++;
            $display("FAIL slip.new_offset: off=%0d v=%b w=%b required off=6 v=1 w=%b", bus.lock_off, bus.out_valid, bus.out_word, K_CT2);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.out_word, bus.out_ctrl, bus.out_c, bus.locked, bus.lock_off} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset.outputs: got %h required 0", {bus.out_valid, bus.out_word, bus.out_ctrl, bus.out_c, bus.locked, bus.lock_off});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bitq.delete();
        add_gap_bits(3);
        for (int k = 0; k < 9; k++) begin
            push_sym(K_CT2);
            n_tests++;
            if (bus.locked !== (k == 8)) begin
                n_fail++;
                $display("FAIL async_reset.relock%0d: locked=%b required %b", k, bus.locked, (k == 8));
            end
        end
    endtask

    task automatic test_interrupted_verify();
        do_reset();
        add_gap_bits(7);
        for (int k = 0; k < 5; k++) push_sym(K_CT1);
        push_sym(10'b0000000000);
        push_sym(K_CT1);
        n_tests++;
        if (bus.locked !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL verify.after_miss: locked=%b v=%b required 0 0", bus.locked, bus.out_valid);
        end
        for (int j = 0; j < 8; j++) begin
            push_sym(K_CT1);
            n_tests++;
            if (bus.locked !== (j == 7)) begin
                n_fail++;
                $display("FAIL verify.reacquire%0d: locked=%b required %b", j, bus.locked, (j == 7));
            end
        end
        n_tests++;
        if (bus.lock_off !== 4'd7) begin
            n_fail++;
            $display("FAIL verify.lock_off: got %0d required 7", bus.lock_off);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_blanking();
        test_stall();
        test_slip();
        test_async_reset();
        test_interrupted_verify();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
